branch_cmp_seq: RTL and testbench
=================================

# branch_cmp_seq

Parametrised, iterative branch comparator for the ID stage. It compares two WIDTH-bit operands SLICE bits per cycle, MSB slice first, and stops at the first differing slice. It supports eight branch conditions and produces a registered taken/equal result behind a valid/ready handshake. A synchronous flush input lets the hazard/flush logic abandon an in-flight comparison.

## Interface
- WIDTH, 32: operand width in bits. Must be a multiple of SLICE.
- SLICE, 8: bits compared per cycle. SLICE == WIDTH gives single-cycle resolution.
- NSLICE, WIDTH/SLICE: derived value, not overridable.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- mode  in  3  0 EQ, 1 NE, 2 LEZ, 3 GTZ, 4 LTZ, 5 GEZ, 6 LT (signed), 7 LTU (unsigned)
- rs  in  WIDTH  first operand
- rt  in  WIDTH  second operand; ignored for modes 2–5, which use 0
- flush  in  1  synchronous abort, highest priority after reset
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- taken  out  1  branch condition true
- equal  out  1  operands equal; driven 0 in LTZ/GEZ

## Operation
- States:
  - IDLE: in_ready = 1.
  - SCAN: slice index idx, counting from NSLICE-1 down to 0.
  - DONE: out_valid = 1.
- in_ready = (state == IDLE) & ~flush.
- Acceptance edge, when in_valid & in_ready:
  - Latch rs, the comparison operand b (rt, or 0 for modes 2–5), and mode.
  - Set idx = NSLICE-1 and go to SCAN.
- LTZ and GEZ do not scan the slices:
  - The first SCAN edge resolves them from rs[WIDTH-1].
  - LTZ: taken = rs[WIDTH-1]. GEZ: taken = ~rs[WIDTH-1].
- Every other mode, on each SCAN edge, compares slice idx of a = rs against b:
  - Slices differ: set lt = (a slice < b slice), eq = 0, then go to DONE.
  - Signed modes (LT, LEZ, GTZ): in the top slice, invert the MSB of both a and b before the unsigned compare.
  - Slices equal and idx == 0: eq = 1, lt = 0, go to DONE.
  - Slices equal otherwise: idx decrements.
- Taken:
  - EQ: eq. NE: ~eq.
  - LEZ: lt | eq. GTZ: ~lt & ~eq.
  - LT and LTU: lt.
- DONE:
  - taken and equal are held stable while out_valid & ~out_ready.
  - An edge with out_valid & out_ready moves to IDLE.
  - No new request is accepted in the same cycle.
- flush high at any edge, in any state:
  - Go to IDLE, out_valid = 0, discard latched operands.
  - A simultaneous in_valid is not accepted.
  - A simultaneous out_ready does not count as a consumed result.
- reset_n low, asynchronous, at any time including mid-SCAN:
  - state = IDLE, idx = 0, out_valid = 0, taken = 0, equal = 0.
  - in_ready reads 1 after reset.

## Timing
- Latency from the acceptance edge to out_valid is k edges:
  - LTZ/GEZ: k = 1.
  - Other modes: k = NSLICE - i, where i is the index of the highest differing slice.
  - All slices equal: k = NSLICE.
- Worst-case occupancy is NSLICE + 2 cycles: acceptance, NSLICE scan edges, handshake.
- All outputs except in_ready are registered. in_ready depends combinationally on flush.
- Arithmetic is unsigned SLICE-bit compare per slice. Signedness is applied only through the top-slice MSB inversion. There is no carry chain across slices.

## Structure
- Shared package branch_cmp_pkg holds:
  - the mode enum: CMP_EQ … CMP_LTU
  - the state enum: IDLE/SCAN/DONE
  - a function computing taken from mode, eq and lt. The forwarding/hazard unit uses the same function.
- Sub-module cmp_slice is combinational:
  - Parameters: SLICE.
  - Inputs: a, b, signed_top.
  - Outputs: eq, lt.
  - It is instantiated once and fed through an idx-selected mux.
- Elaboration check: WIDTH % SLICE == 0.

## Test plan
Configuration: WIDTH=32, SLICE=8.
- EQ, rs = rt = 0xDEADBEEF -> out_valid 4 edges after acceptance, taken=1, equal=1.
- LT, rs=0x80000000, rt=0x00000001 -> resolves in 1 edge, taken=1. The same operands in LTU -> taken=0, equal=0.
- NE, rs=0x12345678, rt=0x12345679 -> 4 edges, taken=1, equal=0.
- Zero-compare modes:
  - GEZ rs=0x7FFFFFFF -> 1 edge, taken=1.
  - LTZ rs=0xFFFFFFFF -> 1 edge, taken=1.
  - LEZ rs=0 -> 4 edges, taken=1.
  - GTZ rs=0x00000100 -> 3 edges, taken=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> taken and equal stable, in_ready=0, a concurrent in_valid is ignored. After the out_ready edge, in_ready=1.
- Abort and reset:
  - flush on the 2nd SCAN edge of an EQ -> IDLE at that edge, out_valid never rises.
  - reset_n low mid-SCAN -> all outputs 0 immediately, in_ready=1.
  - A fresh EQ after release completes normally.

Source files
------------

// File: rtl/branch_cmp_pkg.sv
// Purpose : shared types and helpers for the iterative branch comparator and the forwarding/hazard unit.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package branch_cmp_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LEZ = 3'd2,
    CMP_GTZ = 3'd3,
    CMP_LTZ = 3'd4,
    CMP_GEZ = 3'd5,
    CMP_LT  = 3'd6,
    CMP_LTU = 3'd7
  } cmp_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // Modes that compare rs against zero instead of rt.
  function automatic logic is_zero_cmp(cmp_mode_e mode);
    return (mode == CMP_LEZ) || (mode == CMP_GTZ) ||
           (mode == CMP_LTZ) || (mode == CMP_GEZ);
  endfunction

  // Modes resolved from the sign bit alone, without a slice scan.
  function automatic logic is_sign_only(cmp_mode_e mode);
    return (mode == CMP_LTZ) || (mode == CMP_GEZ);
  endfunction

  // Modes that treat the operands as two's complement.
  function automatic logic is_signed_cmp(cmp_mode_e mode);
    return (mode == CMP_LT) || (mode == CMP_LEZ) || (mode == CMP_GTZ);
  endfunction

  // Branch decision from the compare flags. For LTZ/GEZ, lt carries the
  // sign bit of rs and eq is 0.
  function automatic logic cmp_taken(cmp_mode_e mode, logic eq, logic lt);
    logic t;
    case (mode)
      CMP_EQ:  t = eq;
      CMP_NE:  t = ~eq;
      CMP_LEZ: t = lt | eq;
      CMP_GTZ: t = ~lt & ~eq;
      CMP_LTZ: t = lt;
      CMP_GEZ: t = ~lt;
      CMP_LT:  t = lt;
      CMP_LTU: t = lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_cmp_seq_cmp_slice.sv
// Purpose : combinational unsigned compare of one operand slice, with optional sign handling.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; no handshake.
// Ports   : a, b       - SLICE-bit operand slices
//           signed_top - slice holds the operand sign bits; flip both MSBs so the
//                        unsigned compare orders two's complement values
//           eq, lt     - a == b, a < b (after the optional MSB flip)
module cmp_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             signed_top,
  output logic             eq,
  output logic             lt
);

  logic [SLICE-1:0] a_m;
  logic [SLICE-1:0] b_m;

  always_comb begin
    a_m = a;
    b_m = b;
    if (signed_top) begin
      a_m[SLICE-1] = ~a[SLICE-1];
      b_m[SLICE-1] = ~b[SLICE-1];
    end
    // Flipping both MSBs never changes equality, so compare the raw slices.
    eq = (a == b);
    lt = (a_m < b_m);
  end

endmodule

// File: rtl/branch_cmp_seq.sv
// Purpose : iterative MSB-first branch comparator, SLICE bits per cycle, early exit on first difference.
// Latency : 1 edge for LTZ/GEZ, else NSLICE - (highest differing slice), NSLICE when equal.
// Backpr. : result held in DONE until out_ready; no new request accepted until then.
// Ports   : clk, reset_n (async active-low); in_valid/in_ready + mode/rs/rt request;
//           flush (synchronous abort); out_valid/out_ready + taken/equal registered result.
module branch_cmp_seq
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             equal
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("branch_cmp_seq: WIDTH must be a multiple of SLICE");
  end

  cmp_state_e                   state_q, state_d;
  logic [IDXW-1:0]              idx_q, idx_d;
  logic [NSLICE-1:0][SLICE-1:0] a_q, a_d;
  logic [NSLICE-1:0][SLICE-1:0] b_q, b_d;
  cmp_mode_e                    mode_q, mode_d;
  logic                         out_valid_q, out_valid_d;
  logic                         taken_q, taken_d;
  logic                         equal_q, equal_d;

  cmp_mode_e mode_in;
  logic      sl_eq;
  logic      sl_lt;
  logic      signed_top;

  assign mode_in = cmp_mode_e'(mode);

  // Sign handling only matters in the slice holding the operand MSBs.
  assign signed_top = (idx_q == IDX_TOP) && is_signed_cmp(mode_q);

  cmp_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a         (a_q[idx_q]),
    .b         (b_q[idx_q]),
    .signed_top(signed_top),
    .eq        (sl_eq),
    .lt        (sl_lt)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    equal_d     = equal_q;

    if (flush) begin
      // Abort wins over acceptance and over a result handshake.
      state_d     = IDLE;
      idx_d       = '0;
      a_d         = '0;
      b_d         = '0;
      mode_d      = CMP_EQ;
      out_valid_d = 1'b0;
      taken_d     = 1'b0;
      equal_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // flush is low here, so in_ready == 1 and in_valid alone accepts.
          if (in_valid) begin
            a_d     = rs;
            b_d     = is_zero_cmp(mode_in) ? '0 : rt;
            mode_d  = mode_in;
            idx_d   = IDX_TOP;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (is_sign_only(mode_q)) begin
            taken_d     = cmp_taken(mode_q, 1'b0, a_q[NSLICE-1][SLICE-1]);
            equal_d     = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (!sl_eq) begin
            taken_d     = cmp_taken(mode_q, 1'b0, sl_lt);
            equal_d     = 1'b0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (idx_q == '0) begin
            taken_d     = cmp_taken(mode_q, 1'b1, 1'b0);
            equal_d     = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= CMP_EQ;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      equal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      equal_q     <= equal_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~flush;
  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign equal     = equal_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Purpose : self-checking bench for branch_cmp_seq (WIDTH=32, SLICE=8).
// Latency : n/a.
// Backpr. : exercises held results under out_ready low.
module tb_branch_cmp_seq;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  localparam logic [2:0] M_EQ  = 3'd0;
  localparam logic [2:0] M_NE  = 3'd1;
  localparam logic [2:0] M_LEZ = 3'd2;
  localparam logic [2:0] M_GTZ = 3'd3;
  localparam logic [2:0] M_LTZ = 3'd4;
  localparam logic [2:0] M_GEZ = 3'd5;
  localparam logic [2:0] M_LT  = 3'd6;
  localparam logic [2:0] M_LTU = 3'd7;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       mode;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             equal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_cmp_seq #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .rs       (rs),
    .rt       (rt),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .taken    (taken),
    .equal    (equal)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic        taken;
    logic        equal;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference computed from full-width signed/unsigned arithmetic.
  function automatic void model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rt_i,
                                output int lat, output logic tk, output logic eq);
    logic [31:0] b;
    logic [31:0] diff;
    b = (m >= M_LEZ && m <= M_GEZ) ? 32'd0 : rt_i;
    if (m == M_LTZ || m == M_GEZ) begin
      lat = 1;
      eq  = 1'b0;
      tk  = (m == M_LTZ) ? ($signed(a) < 0) : ($signed(a) >= 0);
      return;
    end
    eq   = (a == b);
    lat  = NSLICE;
    diff = a ^ b;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) begin
        lat = NSLICE - i / SLICE;
        break;
      end
    end
    case (m)
      M_EQ:    tk = eq;
      M_NE:    tk = !eq;
      M_LEZ:   tk = ($signed(a) <= $signed(b));
      M_GTZ:   tk = ($signed(a) >  $signed(b));
      M_LT:    tk = ($signed(a) <  $signed(b));
      default: tk = (a < b);
    endcase
  endfunction

  // Issue one request from IDLE at a negedge; return edges to out_valid and the result.
  task automatic issue(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic tk, output logic eqo);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("wait_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    mode     = m;
    rs       = a;
    rt       = b;
    @(negedge clk);
    in_valid = 1'b0;
    rs       = $urandom;
    rt       = $urandom;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tk  = taken;
    eqo = equal;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic tk;
    logic eqo;
    int   exp_lat;
    logic exp_tk;
    logic exp_eq;
    logic seen;

    vecs[0]  = '{M_EQ,  32'hDEADBEEF, 32'hDEADBEEF, 4, 1'b1, 1'b1};
    vecs[1]  = '{M_LT,  32'h80000000, 32'h00000001, 1, 1'b1, 1'b0};
    vecs[2]  = '{M_LTU, 32'h80000000, 32'h00000001, 1, 1'b0, 1'b0};
    vecs[3]  = '{M_NE,  32'h12345678, 32'h12345679, 4, 1'b1, 1'b0};
    vecs[4]  = '{M_GEZ, 32'h7FFFFFFF, 32'hFFFFFFFF, 1, 1'b1, 1'b0};
    vecs[5]  = '{M_LTZ, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1, 1'b0};
    vecs[6]  = '{M_LEZ, 32'h00000000, 32'h12345678, 4, 1'b1, 1'b1};
    vecs[7]  = '{M_GTZ, 32'h00000100, 32'hFFFFFFFF, 3, 1'b1, 1'b0};
    vecs[8]  = '{M_LT,  32'h00000001, 32'hFFFFFFFF, 1, 1'b0, 1'b0};
    vecs[9]  = '{M_EQ,  32'h11223344, 32'h11223345, 4, 1'b0, 1'b0};
    vecs[10] = '{M_GTZ, 32'h80000000, 32'h00000000, 1, 1'b0, 1'b0};
    vecs[11] = '{M_LEZ, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1, 1'b0};
    vecs[12] = '{M_LTU, 32'h00010000, 32'h00020000, 2, 1'b1, 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    mode      = 3'd0;
    rs        = '0;
    rt        = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_taken",     {31'd0, taken},     32'd0);
    check("rst_equal",     {31'd0, equal},     32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].mode, vecs[i].rs, vecs[i].rt, lat, tk, eqo);
      check($sformatf("vec%0d_lat", i),   lat,            vecs[i].lat);
      check($sformatf("vec%0d_taken", i), {31'd0, tk},  {31'd0, vecs[i].taken});
      check($sformatf("vec%0d_equal", i), {31'd0, eqo}, {31'd0, vecs[i].equal});
      @(negedge clk);
      check($sformatf("vec%0d_drain", i), {30'd0, out_valid, in_ready}, 32'd1);
    end

    // Backpressure: result held, in_ready low, concurrent request ignored.
    out_ready = 1'b0;
    issue(M_EQ, 32'hA5A50000, 32'hA5A50000, lat, tk, eqo);
    check("bp_lat", lat, 4);
    in_valid = 1'b1;
    mode     = M_NE;
    rs       = 32'h1;
    rt       = 32'h2;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d", c), {28'd0, out_valid, taken, equal, in_ready}, 32'hE);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("bp_no_ghost", {31'd0, seen}, 32'd0);

    // Asynchronous reset mid-SCAN (taken/equal still 1 from the held result).
    in_valid = 1'b1;
    mode     = M_EQ;
    rs       = 32'h0F0F0F0F;
    rt       = 32'h0F0F0F0F;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_outputs", {29'd0, out_valid, taken, equal}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(M_EQ, 32'hDEADBEEF, 32'hDEADBEEF, lat, tk, eqo);
    check("post_rst_lat", lat, 4);
    check("post_rst_res", {30'd0, tk, eqo}, 32'd3);
    @(negedge clk);

    // Flush in IDLE blocks acceptance.
    flush    = 1'b1;
    in_valid = 1'b1;
    mode     = M_EQ;
    rs       = '0;
    rt       = '0;
    #1;
    check("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    seen     = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush_idle_no_accept", {31'd0, seen}, 32'd0);

    // Flush on the second SCAN edge of an EQ.
    in_valid = 1'b1;
    mode     = M_EQ;
    rs       = 32'h5555AAAA;
    rt       = 32'h5555AAAA;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_scan_idle", {30'd0, out_valid, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush_scan_no_result", {31'd0, seen}, 32'd0);

    // Flush in DONE together with out_ready.
    out_ready = 1'b0;
    issue(M_LTU, 32'h1, 32'h2, lat, tk, eqo);
    check("flush_done_lat", lat, NSLICE);
    check("flush_done_taken", {31'd0, tk}, 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_done_idle", {30'd0, out_valid, in_ready}, 32'd1);
    @(negedge clk);

    // Randomized against the reference model.
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  m;
      logic [31:0] a;
      logic [31:0] b;
      m = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'd1 << $urandom_range(0, 31));
        default: begin
          a = ($urandom_range(0, 1) != 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
          b = $urandom;
        end
      endcase
      model(m, a, b, exp_lat, exp_tk, exp_eq);
      issue(m, a, b, lat, tk, eqo);
      check($sformatf("rnd%0d_lat m%0d a%08h b%08h", n, m, a, b), lat, exp_lat);
      check($sformatf("rnd%0d_taken", n), {31'd0, tk},  {31'd0, exp_tk});
      check($sformatf("rnd%0d_equal", n), {31'd0, eqo}, {31'd0, exp_eq});
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
